// File: rtl/pipe_checker_pkg.sv
// Shared types and helpers for the pipeline latency checker.
package pipe_checker_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Upper bound on history taps; MAX_LAT must stay below this.
    localparam int MAX_TAPS = 32;

    function automatic logic [4:0] lowest_hit(input logic [MAX_TAPS-1:0] hits);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_TAPS - 1; i >= 0; i--) begin
            if (hits[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipe_checker_hist.sv
// Stimulus history: taps[0] is the live input, taps[k] is d from k samples ago.
// fill counts consumed samples (saturating at MAX_LAT) so stale taps can be masked.
module pipe_checker_hist #(
    parameter int WIDTH   = 8,
    parameter int MAX_LAT = 4,
    parameter int FILL_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              d,
    output logic [MAX_LAT:0][WIDTH-1:0]   taps,
    output logic [FILL_W-1:0]             fill
);

    logic [FILL_W-1:0] fill_d, fill_q;

    always_comb begin
        fill_d = fill_q;
        if (en && (fill_q != FILL_W'(MAX_LAT))) fill_d = fill_q + FILL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) fill_q <= '0;
        else     fill_q <= fill_d;
    end

    assign fill = fill_q;

    generate
        if (MAX_LAT > 0) begin : g_sr
            // sr_q[i] holds d from i+1 samples ago
            logic [MAX_LAT-1:0][WIDTH-1:0] sr_d, sr_q;

            always_comb begin
                sr_d = sr_q;
                if (en) begin
                    sr_d[0] = d;
                    for (int i = 1; i < MAX_LAT; i++) sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) sr_q <= '0;
                else     sr_q <= sr_d;
            end

            assign taps = {sr_q, d};
        end else begin : g_pass
            assign taps = d;
        end
    endgenerate

endmodule

// File: rtl/pipe_checker.sv
// Pipeline latency finder and checker. Optional mismatch capture ports are
// enabled by defining PIPE_CHECKER_CAPTURE_EN.
module pipe_checker
    import pipe_checker_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_LAT   = 4,
    parameter int LOCK_LEN  = 4,
    parameter int LOSS_LEN  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [WIDTH-1:0]             d,
    input  logic [WIDTH-1:0]             q,
    output logic                         locked,
    output logic [$clog2(MAX_LAT+1)-1:0] latency,
    output logic                         mismatch,
    output logic                         err,
    output logic [ERR_CNT_W-1:0]         err_cnt
`ifdef PIPE_CHECKER_CAPTURE_EN
    ,
    output logic                         cap_valid,
    output logic [WIDTH-1:0]             cap_exp,
    output logic [WIDTH-1:0]             cap_got
`endif
);

    localparam int LAT_W  = $clog2(MAX_LAT + 1);
    localparam int RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int MISS_W = $clog2(LOSS_LEN + 1);

    logic [MAX_LAT:0][WIDTH-1:0] taps;
    logic [LAT_W-1:0]            fill;

    pipe_checker_hist #(
        .WIDTH   (WIDTH),
        .MAX_LAT (MAX_LAT),
        .FILL_W  (LAT_W)
    ) u_hist (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .d    (d),
        .taps (taps),
        .fill (fill)
    );

    // Only taps already filled by real samples may match.
    logic [MAX_TAPS-1:0] hits;
    logic                cand_hit;
    logic [LAT_W-1:0]    cand_idx;

    always_comb begin
        hits = '0;
        for (int k = 0; k <= MAX_LAT; k++) begin
            hits[k] = (q == taps[k]) && (fill >= LAT_W'(k));
        end
    end

    assign cand_hit = |hits;
    assign cand_idx = LAT_W'(lowest_hit(hits));

    chk_state_t           state_d, state_q;
    logic [LAT_W-1:0]     cand_d, cand_q;
    logic [LAT_W-1:0]     latency_d, latency_q;
    logic [RUN_W-1:0]     run_d, run_q;
    logic [MISS_W-1:0]    miss_d, miss_q;
    logic                 mismatch_d, mismatch_q;
    logic                 err_d, err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic [WIDTH-1:0]     exp_word, ver_word;

    assign exp_word = taps[latency_q];
    assign ver_word = taps[cand_q];

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        latency_d  = latency_q;
        run_d      = run_q;
        miss_d     = miss_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        if (en) begin
            unique case (state_q)
                SEARCH: begin
                    if (cand_hit) begin
                        cand_d = cand_idx;
                        if (LOCK_LEN == 1) begin
                            state_d   = LOCKED;
                            latency_d = cand_idx;
                            miss_d    = '0;
                        end else begin
                            state_d = VERIFY;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                VERIFY: begin
                    if (q == ver_word) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_d == RUN_W'(LOCK_LEN)) begin
                            state_d   = LOCKED;
                            latency_d = cand_q;
                            miss_d    = '0;
                            run_d     = '0;
                        end
                    end else begin
                        // Fresh search starts on the next sample, not this one.
                        state_d = SEARCH;
                        run_d   = '0;
                    end
                end
                LOCKED: begin
                    if (q != exp_word) begin
                        mismatch_d = 1'b1;
                        err_d      = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        miss_d = miss_q + MISS_W'(1);
                        if (miss_d == MISS_W'(LOSS_LEN)) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEARCH;
            cand_q     <= '0;
            latency_q  <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            latency_q  <= latency_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign latency  = latency_q;
    assign mismatch = mismatch_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

`ifdef PIPE_CHECKER_CAPTURE_EN
    logic             cap_valid_d, cap_valid_q;
    logic [WIDTH-1:0] cap_exp_d, cap_exp_q;
    logic [WIDTH-1:0] cap_got_d, cap_got_q;

    // Freeze the first offending expected/actual pair until reset.
    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_exp_d   = cap_exp_q;
        cap_got_d   = cap_got_q;
        if (mismatch_d && !cap_valid_q) begin
            cap_valid_d = 1'b1;
            cap_exp_d   = exp_word;
            cap_got_d   = q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_exp_q   <= '0;
            cap_got_q   <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_exp_q   <= cap_exp_d;
            cap_got_q   <= cap_got_d;
        end
    end

    assign cap_valid = cap_valid_q;
    assign cap_exp   = cap_exp_q;
    assign cap_got   = cap_got_q;
`endif

endmodule

// File: doc/pipe_checker.md
# pipe_checker

Synthesizable self-checking monitor for the pipeline experiments. It samples the stimulus word `d` and the output `q` of a pipeline under test, and finds the pipeline latency in samples. Once locked, it checks every later sample against the delayed stimulus, counting and flagging mismatches. Every `pipeb*`/`pipen*` variant, behavioural or synthesised, then gets a hardware pass/fail verdict instead of relying on waveform inspection.

## Interface
- `WIDTH`, 8, data width of `d` and `q`
- `MAX_LAT`, 4, largest latency searched, in samples (0 is pass-through)
- `LOCK_LEN`, 4, consecutive matching samples required to lock, at least 1
- `LOSS_LEN`, 2, consecutive mismatching samples while locked that drop lock, at least 1
- `ERR_CNT_W`, 8, width of the mismatch counter

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  sample strobe; `d` and `q` are evaluated only on cycles with `en`=1
- `d`  in  WIDTH  stimulus word fed to the pipeline under test
- `q`  in  WIDTH  pipeline output (`q3`)
- `locked`  out  1  latency identified and being checked
- `latency`  out  $clog2(MAX_LAT+1)  identified latency, valid while `locked`
- `mismatch`  out  1  one-cycle pulse for each mismatching sample while locked
- `err`  out  1  sticky; set on first `mismatch`, cleared only by `rst`
- `err_cnt`  out  ERR_CNT_W  count of mismatches while locked, saturating at all-ones

## Operation
- History `hist[k]`, k=0..MAX_LAT: `hist[0]` is the current `d`, and `hist[k]` is `d` from k samples earlier.
  - Fill counter `fill` saturates at MAX_LAT.
  - `hist[k]` is valid only when `fill` ≥ k.
- Latency L means that `q` equals `hist[L]` on the same sample.
- FSM states are SEARCH, VERIFY and LOCKED; reset state is SEARCH.
  - **SEARCH:** `cand` is the lowest valid k with `q`==`hist[k]`. If one exists, go to VERIFY with `run`=1; otherwise stay.
  - **VERIFY:**
    - On a match, `run`++. When `run` reaches LOCK_LEN, go to LOCKED and set `latency`=`cand`.
    - On a mismatch, go to SEARCH. The search does not rerun on that same sample.
    - With LOCK_LEN=1, SEARCH goes straight to LOCKED.
  - **LOCKED:** compare `q` with `hist[latency]`.
    - On a mismatch: pulse `mismatch`, increment `err_cnt` (saturating), set `err`, and increment `miss`.
    - On a match, clear `miss`.
    - When `miss` reaches LOSS_LEN, go to SEARCH and drop `locked`. `err_cnt` and `err` are kept.
- Mismatches are not counted in SEARCH or VERIFY.
- `en`=0: history, `fill`, FSM and counters all hold, and `mismatch`=0.
- Reset values: `locked`=0, `latency`=0, `mismatch`=0, `err`=0, `err_cnt`=0, `fill`=0, all `hist`=0, `run`=0, `miss`=0.
- Reset mid-operation returns everything to these values on the next edge, and locking restarts from an empty history.

## Timing
- All outputs are registered and update on the `clk` edge that consumes the sample (`en`=1).
- `mismatch` is high for exactly the cycle after the mismatching sample.
- `locked` rises on the edge that consumes the LOCK_LEN-th consecutive matching sample.
- `locked` falls on the edge that consumes the LOSS_LEN-th consecutive mismatching sample. That sample still pulses `mismatch`.
- Minimum lock time with latency L is L+LOCK_LEN samples after reset.
- `rst` has priority over `en`.

## Configuration
- `PIPE_CHECKER_CAPTURE_EN` defined: adds output ports `cap_valid` (1 bit), `cap_exp` (WIDTH) and `cap_got` (WIDTH).
  - On the first `mismatch` after reset, they latch `hist[latency]` and `q` and set `cap_valid`.
  - They then hold until `rst`, which resets all three to 0.
- Not defined: these ports and registers do not exist, and all other behaviour is identical.

## Structure
- Package `pipe_checker_pkg`:
  - state enum `chk_state_t` (SEARCH, VERIFY, LOCKED)
  - a function returning the lowest matching history index
- Sub-module `pipe_checker_hist`: history shift register plus `fill` counter, with `en` and `rst` and all MAX_LAT+1 taps exposed.
- The FSM, counters and capture logic live in the top level.

## Test plan
All scenarios use default parameters unless stated.

1. **Lock on latency 3.** Model latency 3 with reset output 0; `d`=0x10,0x11,… with `en` every cycle.
   - Required: `locked`=1 with `latency`=3 after the 7th sample, and `err_cnt`=0.
2. **Single error.** While locked, XOR `q` with 0x01 on one sample.
   - Required: one `mismatch` pulse, `err_cnt`=1 and `err`=1, with `locked` staying 1.
3. **Loss and relock.** Corrupt two consecutive samples.
   - Required: `err_cnt`=2 and `locked`=0, then relock at latency 3 after 4 clean samples, with `err` still 1.
4. **Strobe gaps.** Hold `en`=0 for 3 cycles mid-stream while `d` and `q` change arbitrarily.
   - Required: no `mismatch` and no state change; checking resumes cleanly.
5. **Reset mid-VERIFY.** Assert `rst` at `run`=2.
   - Required: every output is 0 on the next edge, and relock takes 7 samples again.
6. **Saturation and capture.** With `ERR_CNT_W`=2 and `LOSS_LEN`=8, inject 5 isolated errors.
   - Required: `err_cnt`=3.
   - With `PIPE_CHECKER_CAPTURE_EN`: `cap_exp`/`cap_got` hold the first expected/actual pair, and `cap_valid`=1.
